// File: rtl/ex_mem_skid_reg_pkg.sv
// Shared EX/MEM pipeline types: payload struct, skid-buffer state encoding.
package ex_mem_skid_reg_pkg;

   localparam int unsigned EX_MEM_DW = 32;
   localparam int unsigned EX_MEM_RW = 5;
   localparam int unsigned EX_MEM_CW = 16;

   // Payload carried from execute to memory (also reused by the MEM/WB register).
   typedef struct packed {
      logic                 wb_en;
      logic                 mem_r_en;
      logic                 mem_w_en;
      logic [EX_MEM_RW-1:0] dest;
      logic [EX_MEM_DW-1:0] alu_res;
      logic [EX_MEM_DW-1:0] st_value;
      logic [EX_MEM_DW-1:0] pc;
   } ex_mem_payload_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

endpackage

// File: rtl/ex_mem_skid_reg_pipe_slot.sv
// Loadable payload register with synchronous active-low clear.
module ex_mem_skid_reg_pipe_slot
   import ex_mem_skid_reg_pkg::*;
(
   input  logic            clk,
   input  logic            clr_n,
   input  logic            load,
   input  ex_mem_payload_t d,
   output ex_mem_payload_t q
);

   ex_mem_payload_t slot_q;
   ex_mem_payload_t slot_d;

   // Hold unless a load is requested.
   always_comb begin
      slot_d = slot_q;
      if (load) begin
         slot_d = d;
      end
   end

   // Slot storage, cleared to zero on reset.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign q = slot_q;

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a two-entry skid buffer and forwarding export.
// DW/RW must match the package payload widths.
module ex_mem_skid_reg
   import ex_mem_skid_reg_pkg::*;
#(
   parameter int unsigned DW = EX_MEM_DW,
   parameter int unsigned RW = EX_MEM_RW,
   parameter int unsigned CW = EX_MEM_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_WB_EN,
   input  logic          in_MEM_R_EN,
   input  logic          in_MEM_W_EN,
   input  logic [RW-1:0] in_dest,
   input  logic [DW-1:0] in_ALU_res,
   input  logic [DW-1:0] in_ST_value,
   input  logic [DW-1:0] in_PC,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_WB_EN,
   output logic          out_MEM_R_EN,
   output logic          out_MEM_W_EN,
   output logic [RW-1:0] out_dest,
   output logic [DW-1:0] out_ALU_res,
   output logic [DW-1:0] out_ST_value,
   output logic [DW-1:0] out_PC,
   output logic          fwd_valid,
   output logic [RW-1:0] fwd_dest,
   output logic [CW-1:0] stall_cnt
);

   localparam logic [CW-1:0] STALL_MAX = '1;

   skid_state_e     state_q, state_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic [CW-1:0]   stall_cnt_q, stall_cnt_d;

   ex_mem_payload_t in_pl;
   ex_mem_payload_t main_d, main_q, skid_q;
   logic            main_load, skid_load;
   logic            accept, pop;

   assign in_pl = '{wb_en:    in_WB_EN,
                    mem_r_en: in_MEM_R_EN,
                    mem_w_en: in_MEM_W_EN,
                    dest:     in_dest,
                    alu_res:  in_ALU_res,
                    st_value: in_ST_value,
                    pc:       in_PC};

   assign accept = in_valid & in_ready_q;
   assign pop    = out_valid_q & out_ready;

   // Next state, slot load strobes, ready/valid and stall counter.
   always_comb begin
      state_d     = state_q;
      main_load   = 1'b0;
      skid_load   = 1'b0;
      main_d      = in_pl;
      stall_cnt_d = stall_cnt_q;

      unique case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d   = ST_ONE;
               main_load = 1'b1;
            end
         end
         ST_ONE: begin
            case ({accept, pop})
               2'b10: begin
                  state_d   = ST_TWO;
                  skid_load = 1'b1;
               end
               2'b01:   state_d   = ST_EMPTY;
               2'b11:   main_load = 1'b1;
               default: ;
            endcase
         end
         ST_TWO: begin
            // in_ready is low here, so only a pop can move the buffer.
            if (pop) begin
               state_d   = ST_ONE;
               main_load = 1'b1;
               main_d    = skid_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // Flush drops everything, including an accept in the same cycle.
      if (flush) begin
         state_d   = ST_EMPTY;
         main_load = 1'b0;
         skid_load = 1'b0;
      end

      in_ready_d  = (state_d != ST_TWO);
      out_valid_d = (state_d != ST_EMPTY);

      if (out_valid_q && !out_ready && (stall_cnt_q != STALL_MAX)) begin
         stall_cnt_d = stall_cnt_q + CW'(1);
      end
   end

   // Control state registers; reset wins over flush and handshakes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   ex_mem_skid_reg_pipe_slot u_main (
      .clk   (clk),
      .clr_n (rst),
      .load  (main_load),
      .d     (main_d),
      .q     (main_q)
   );

   ex_mem_skid_reg_pipe_slot u_skid (
      .clk   (clk),
      .clr_n (rst),
      .load  (skid_load),
      .d     (in_pl),
      .q     (skid_q)
   );

   // Control bits are masked when no entry is offered.
   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_WB_EN    = main_q.wb_en    & out_valid_q;
   assign out_MEM_R_EN = main_q.mem_r_en & out_valid_q;
   assign out_MEM_W_EN = main_q.mem_w_en & out_valid_q;
   assign out_dest     = main_q.dest;
   assign out_ALU_res  = main_q.alu_res;
   assign out_ST_value = main_q.st_value;
   assign out_PC       = main_q.pc;
   assign fwd_valid    = out_valid_q & main_q.wb_en;
   assign fwd_dest     = main_q.dest;
   assign stall_cnt    = stall_cnt_q;

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
Pipeline register between the execute stage and the memory stage. It carries the execute result, store data and control bits, and presents them to the memory stage's data-memory access. It uses a valid/ready handshake with a two-entry skid buffer, so a multi-cycle or stalled data memory can back-pressure execute without a combinational ready path. It also exports the forwarding information for the entry currently offered to the memory stage.

Parameters:
- DW, 32: data and address width (ALU_res, ST_value, PC).
- RW, 5: destination register index width.
- CW, 16: stall-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- flush  in  1  drop all buffered entries (branch taken).
- in_valid  in  1  execute offers an entry.
- in_ready  out  1  register accepts an entry; driven from a flop.
- in_WB_EN  in  1  write-back enable.
- in_MEM_R_EN  in  1  load.
- in_MEM_W_EN  in  1  store.
- in_dest  in  RW  destination register.
- in_ALU_res  in  DW  ALU result / memory address.
- in_ST_value  in  DW  store data.
- in_PC  in  DW  instruction PC.
- out_valid  out  1  entry offered to the memory stage.
- out_ready  in  1  memory stage consumes the entry.
- out_WB_EN, out_MEM_R_EN, out_MEM_W_EN, out_dest, out_ALU_res, out_ST_value, out_PC  out  as the matching inputs  head entry payload.
- fwd_valid  out  1  equals out_valid & out_WB_EN.
- fwd_dest  out  RW  equals out_dest.
- stall_cnt  out  CW  saturating count of cycles with out_valid & !out_ready.

Behaviour:
- Storage is two slots: MAIN (head, drives the out_* ports) and SKID.
- States:
  - EMPTY: no valid slot.
  - ONE: MAIN valid.
  - TWO: MAIN and SKID valid.
- Handshake rules:
  - Accept when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - in_ready = (state != TWO), registered from the next-state value.
  - out_valid = (state != EMPTY).
- Transitions:
  - EMPTY, accept → ONE; the payload loads MAIN.
  - ONE:
    - accept without pop → TWO; the payload loads SKID.
    - pop without accept → EMPTY.
    - accept with pop → ONE; the payload loads MAIN directly.
    - neither → ONE, MAIN unchanged.
  - TWO:
    - pop → ONE; SKID moves to MAIN.
    - no pop → TWO, unchanged.
    - in_ready is 0 in TWO, so no accept occurs.
- Latency: an accepted entry appears on out_* on the next cycle. Throughput is one entry per cycle while out_ready stays high.
- Stability: while out_valid & !out_ready, all out_* payload ports hold their values bit-for-bit.
- Flush:
  - Next state is EMPTY and in_ready becomes 1.
  - A simultaneous accept is discarded; a simultaneous pop still counts as a consumption at the memory stage.
  - stall_cnt is not affected.
- Reset (rst == 0 at a clock edge):
  - State EMPTY.
  - out_valid = 0, in_ready = 1, stall_cnt = 0.
  - Payload registers cleared to 0.
  - Reset overrides flush and any handshake.
- Reset mid-operation: buffered entries are lost; no partial transfer is visible afterwards.
- Invalid-slot payload: when out_valid = 0, the out_* control bits are forced to 0, so the downstream MEM_R_EN and MEM_W_EN are never spuriously asserted.
- stall_cnt increments by 1 per stall cycle and saturates at 2^CW−1 with no wrap.
- No arithmetic is performed on the payload; it passes through unmodified.

Decomposition:
- Shared package:
  - DW/RW defaults.
  - ex_mem_payload_t struct: WB_EN, MEM_R_EN, MEM_W_EN, dest, ALU_res, ST_value, PC.
  - State enum {EMPTY, ONE, TWO}.
- The payload struct is reused later by the MEM/WB register.
- One natural sub-module: pipe_slot, a loadable payload register with a synchronous active-low clear. It is instantiated twice, for MAIN and SKID.

Test Plan:
- Reset then idle: release reset → out_valid=0, in_ready=1, stall_cnt=0, out_MEM_W_EN=0.
- Streaming: out_ready=1; present ALU_res=0x10, 0x14, 0x18 on consecutive cycles → the same values appear one cycle later, one per cycle; in_ready stays 1.
- Back-pressure fill:
  - Hold out_ready=0 and accept A=0x100, then B=0x200 → in_ready=0, out_ALU_res holds 0x100.
  - Raise out_ready → 0x100 then 0x200 on successive cycles, and in_ready returns to 1.
- Flush with simultaneous accept:
  - In state TWO, assert flush plus in_valid (ALU_res=0x300) → next cycle out_valid=0, in_ready=1.
  - 0x300 never appears on the outputs.
- Forwarding:
  - Entry with WB_EN=1, dest=7, held with out_ready=0 → fwd_valid=1, fwd_dest=7.
  - Entry with WB_EN=0 (store) → fwd_valid=0.
- Stall counter saturation and reset priority:
  - With CW=4, hold a stall for 20 cycles → stall_cnt=15.
  - Assert rst=0 together with flush and in_valid → stall_cnt=0, out_valid=0.
